// File: rtl/pixmem_arbiter.sv
// Arbitrates the single-port pixel RAM between display fetches and game-logic req/ack accesses.
// Optional one-entry display tag cache enabled by defining PIXCACHE_EN.
module pixmem_arbiter #(
    parameter int DATA_W     = 3,
    parameter int STARVE_MAX = 31
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_video_on,
    input  logic              i_rom_en,
    input  logic [3:0]        i_pixel_h,
    input  logic [3:0]        i_pixel_v,
    output logic [DATA_W-1:0] o_disp_data,
    output logic              o_disp_stall,
    input  logic              i_game_req,
    input  logic              i_game_we,
    input  logic [7:0]        i_game_addr,
    input  logic [DATA_W-1:0] i_game_wdata,
    output logic [DATA_W-1:0] o_game_rdata,
    output logic              o_game_ack,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [7:0]        o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] C_MAX = CW'(STARVE_MAX);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_GACK = 1'b1;

    // Game handshake: i_game_req rises with we/addr/wdata stable and stays high until
    // o_game_ack pulses for one cycle; o_game_rdata is valid in that ack cycle.
    logic [0:0]        r_state;
    logic [CW-1:0]     r_starve_cnt;
    logic              r_gack_we;
    logic [DATA_W-1:0] r_game_rdata;
    logic              r_fetch;
    logic [DATA_W-1:0] r_disp_q;
    logic              r_stall;

    logic [7:0]        w_da;
    logic              w_vis;
    logic              w_need;
    logic              w_grant;
    logic              w_dfetch;
    logic [DATA_W-1:0] w_disp_next;

    assign w_da  = {i_pixel_v, i_pixel_h};
    assign w_vis = i_video_on & i_rom_en;

`ifdef PIXCACHE_EN
    logic [7:0]        r_tag;
    logic              r_valid;
    logic [DATA_W-1:0] r_cdata;
    logic              w_hit;
    logic              w_wthru;
    logic [DATA_W-1:0] w_hit_data;

    // The entry counts as valid already in the cycle its fetch data arrives on i_mem_rdata.
    assign w_hit      = w_vis & (r_tag == w_da) & (r_valid | r_fetch);
    assign w_need     = w_vis & ~w_hit;
    assign w_wthru    = w_grant & i_game_we & (i_game_addr == r_tag);
    assign w_hit_data = w_wthru ? i_game_wdata : (r_fetch ? i_mem_rdata : r_cdata);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tag   <= '0;
            r_valid <= 1'b0;
            r_cdata <= '0;
        end else begin
            if (w_dfetch) begin
                r_tag   <= w_da;
                r_valid <= 1'b0;
            end else if (r_fetch) begin
                r_valid <= 1'b1;
            end
            if (w_wthru)
                r_cdata <= i_game_wdata;
            else if (r_fetch)
                r_cdata <= i_mem_rdata;
        end
    end
`else
    assign w_need = w_vis;
`endif

    // Combinational RAM drive is gated by reset so the RAM sees nothing while held in reset.
    assign w_grant  = i_rst_n & (r_state == S_IDLE) & i_game_req
                    & (~w_need | (r_starve_cnt == C_MAX));
    assign w_dfetch = i_rst_n & w_need & ~w_grant;

    assign o_mem_en    = w_grant | w_dfetch;
    assign o_mem_we    = w_grant & i_game_we;
    assign o_mem_addr  = w_grant ? i_game_addr : (w_dfetch ? w_da : 8'h00);
    assign o_mem_wdata = (w_grant & i_game_we) ? i_game_wdata : '0;

    assign o_disp_data  = r_fetch ? i_mem_rdata : r_disp_q;
    assign o_disp_stall = r_stall;
    assign o_game_ack   = (r_state == S_GACK);
    assign o_game_rdata = (o_game_ack & ~r_gack_we) ? i_mem_rdata : r_game_rdata;

    always_comb begin
        w_disp_next = o_disp_data;
        if (!w_vis)
            w_disp_next = '0;
`ifdef PIXCACHE_EN
        else if (w_hit)
            w_disp_next = w_hit_data;
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fetch  <= 1'b0;
            r_disp_q <= '0;
            r_stall  <= 1'b0;
        end else begin
            r_fetch <= w_dfetch;
            r_stall <= w_need & w_grant;
            if (!w_dfetch)
                r_disp_q <= w_disp_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_starve_cnt <= '0;
            r_gack_we    <= 1'b0;
            r_game_rdata <= '0;
        end else begin
            r_game_rdata <= o_game_rdata;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_state   <= S_GACK;
                        r_gack_we <= i_game_we;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (!i_game_req || w_grant)
                r_starve_cnt <= '0;
            else if (r_state == S_IDLE && r_starve_cnt != C_MAX)
                r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end
endmodule
